// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared game constants, state encodings and helpers
package dino_pkg;

  localparam logic [1:0] GS_IDLE = 2'd0;
  localparam logic [1:0] GS_RUN  = 2'd1;
  localparam logic [1:0] GS_OVER = 2'd2;

  localparam int SCREEN_W     = 640;
  localparam int DANGER_SLOTS = 3;
  localparam int NUM_TYPES    = 5;
  localparam int POS_W        = 10;
  localparam int TYPE_W       = 3;
  localparam int GAP_W        = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FROZEN
  } sched_state_t;

  // Reserved encoding behaves like OVER so a glitchy game-state never restarts play.
  function automatic sched_state_t decode_gs(input logic [1:0] gs);
    case (gs)
      GS_IDLE: return S_IDLE;
      GS_RUN:  return S_RUN;
      default: return S_FROZEN;
    endcase
  endfunction

  // Fold a 3-bit random draw into 0..n_types-1 with a single subtraction.
  function automatic logic [TYPE_W-1:0] map_type(input logic [TYPE_W-1:0] t, input int n_types);
    if (int'(t) < n_types) return t;
    else return TYPE_W'(int'(t) - n_types);
  endfunction

endpackage

// File: rtl/danger_lfsr.sv
// rtl/danger_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) with advance enable
module danger_lfsr #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [OUT_W-1:0] value
);

  logic [15:0] state_q;
  logic        feedback;

  assign feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
  assign value    = state_q[OUT_W-1:0];

  // Shift left one step per enabled cycle; the seed must be nonzero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= {state_q[14:0], feedback};
    end
  end

endmodule

// File: rtl/danger_spawn_scheduler.sv
// rtl/danger_spawn_scheduler.sv - moves, retires and spawns the three obstacle slots per game tick
module danger_spawn_scheduler
  import dino_pkg::*;
#(
  parameter int          SPAWN_X       = dino_pkg::SCREEN_W,
  parameter int          STEP          = 4,
  parameter int          MIN_GAP       = 40,
  parameter int          GAP_RAND_BITS = 6,
  parameter int          NUM_TYPES     = dino_pkg::NUM_TYPES,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        game_state,
  output logic [POS_W-1:0]  danger_pos1,
  output logic [POS_W-1:0]  danger_pos2,
  output logic [POS_W-1:0]  danger_pos3,
  output logic [TYPE_W-1:0] danger_type1,
  output logic [TYPE_W-1:0] danger_type2,
  output logic [TYPE_W-1:0] danger_type3,
  output logic              danger_en1,
  output logic              danger_en2,
  output logic              danger_en3,
  output logic [1:0]        danger_num
);

  localparam int RAND_W = GAP_RAND_BITS + 3;

  sched_state_t            state_q;
  logic [POS_W-1:0]        pos_q  [DANGER_SLOTS];
  logic [TYPE_W-1:0]       type_q [DANGER_SLOTS];
  logic [DANGER_SLOTS-1:0] en_q;
  logic [GAP_W-1:0]        gap_q;
  logic [1:0]              num_q;

  logic [POS_W-1:0]        pos_d  [DANGER_SLOTS];
  logic [TYPE_W-1:0]       type_d [DANGER_SLOTS];
  logic [DANGER_SLOTS-1:0] en_d;
  logic [GAP_W-1:0]        gap_d;
  logic [1:0]              num_d;

  logic [RAND_W-1:0]       lfsr;
  logic [GAP_W-1:0]        gap_rand;
  logic                    lfsr_adv;
  logic                    free_found;
  logic [1:0]              free_idx;

  assign lfsr_adv = (state_q == S_RUN) && tick;

  danger_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (RAND_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .value   (lfsr)
  );

  if (GAP_RAND_BITS == 0) begin : g_fixed_gap
    assign gap_rand = '0;
  end else begin : g_rand_gap
    assign gap_rand = GAP_W'(lfsr[GAP_RAND_BITS+2:3]);
  end

  // Next slot state for one tick, computed entirely from pre-tick values.
  always_comb begin
    pos_d      = pos_q;
    type_d     = type_q;
    en_d       = en_q;
    gap_d      = gap_q;
    free_found = 1'b0;
    free_idx   = '0;
    // Scan high to low so the lowest free slot wins; uses pre-tick en so a
    // slot retiring this tick is not reused until the next one.
    for (int i = DANGER_SLOTS - 1; i >= 0; i--) begin
      if (!en_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
    for (int i = 0; i < DANGER_SLOTS; i++) begin
      if (en_q[i]) begin
        if (pos_q[i] < POS_W'(STEP)) begin
          en_d[i]  = 1'b0;
          pos_d[i] = '0;
        end else begin
          pos_d[i] = pos_q[i] - POS_W'(STEP);
        end
      end
    end
    if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end else if (free_found) begin
      // Spawn overrides nothing: the chosen slot was idle, so it was not moved.
      pos_d[free_idx]  = POS_W'(SPAWN_X);
      en_d[free_idx]   = 1'b1;
      type_d[free_idx] = map_type(lfsr[2:0], NUM_TYPES);
      gap_d            = GAP_W'(MIN_GAP) + gap_rand;
    end
    num_d = 2'(en_d[0]) + 2'(en_d[1]) + 2'(en_d[2]);
  end

  // Game-state FSM and all slot registers: clear in idle, step on tick in run, hold when frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      gap_q   <= GAP_W'(MIN_GAP);
      num_q   <= '0;
      for (int i = 0; i < DANGER_SLOTS; i++) begin
        pos_q[i]  <= '0;
        type_q[i] <= '0;
      end
    end else begin
      state_q <= decode_gs(game_state);
      case (state_q)
        S_IDLE: begin
          en_q  <= '0;
          gap_q <= GAP_W'(MIN_GAP);
          num_q <= '0;
          for (int i = 0; i < DANGER_SLOTS; i++) begin
            pos_q[i]  <= '0;
            type_q[i] <= '0;
          end
        end
        S_RUN: begin
          if (tick) begin
            pos_q  <= pos_d;
            type_q <= type_d;
            en_q   <= en_d;
            gap_q  <= gap_d;
            num_q  <= num_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign danger_pos1  = pos_q[0];
  assign danger_pos2  = pos_q[1];
  assign danger_pos3  = pos_q[2];
  assign danger_type1 = type_q[0];
  assign danger_type2 = type_q[1];
  assign danger_type3 = type_q[2];
  assign danger_en1   = en_q[0];
  assign danger_en2   = en_q[1];
  assign danger_en3   = en_q[2];
  assign danger_num   = num_q;

endmodule
